// File: rtl/sub16u_apx_pipe.sv
// Approximate unsigned subtractor, two-stage valid/ready pipeline.
// The low K result bits pass A through; a mismatch monitor counts deliveries that differ from exact A-B.
module sub16u_apx_pipe #(
  parameter int W  = 16,
  parameter int K  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    O,
  output logic [CW-1:0] op_cnt,
  output logic [CW-1:0] err_cnt,
  input  logic          cnt_clr
);
  localparam int H  = W - K;
  localparam int M  = H / 2;
  localparam int HH = H - M;

  logic          s1_valid, s1_brw, s2_err;
  logic [HH-1:0] s1_ahi, s1_bhi;
  logic [M-1:0]  s1_lo;
  logic [K-1:0]  s1_alo;
  logic [W:0]    s1_exact;

  logic          bi, s1_adv, in_fire, out_fire;
  logic [M:0]    lo_full;
  logic [HH:0]   hi_full;
  logic [W:0]    exact, approx;

  // Borrow out of the truncated field is guessed from bit K-1 alone.
  assign bi      = ~A[K-1] & B[K-1];
  assign lo_full = {1'b0, A[K+M-1:K]} - {1'b0, B[K+M-1:K]} - {{M{1'b0}}, bi};
  assign exact   = {1'b0, A} - {1'b0, B};
  assign hi_full = {1'b0, s1_ahi} - {1'b0, s1_bhi} - {{HH{1'b0}}, s1_brw};
  assign approx  = {hi_full, s1_lo, s1_alo};

  assign s1_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~rst & (~s1_valid | s1_adv);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst)          s1_valid <= 1'b0;
    else if (in_fire) s1_valid <= 1'b1;
    else if (s1_adv)  s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_ahi   <= A[W-1:K+M];
      s1_bhi   <= B[W-1:K+M];
      s1_lo    <= lo_full[M-1:0];
      s1_brw   <= lo_full[M];
      s1_alo   <= A[K-1:0];
      s1_exact <= exact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      O         <= '0;
      s2_err    <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      O         <= approx;
      s2_err    <= (approx != s1_exact);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (out_fire) begin
      if (op_cnt != '1)            op_cnt  <= op_cnt + CW'(1);
      if (s2_err && err_cnt != '1) err_cnt <= err_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_sub16u_apx_pipe.sv
// Scoreboard bench for sub16u_apx_pipe: directed vectors push expected O into a queue,
// a negedge monitor pops on every output transfer and tracks the expected counters.
module tb_sub16u_apx_pipe;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic        in_ready, out_valid;
  logic [15:0] a = 0, b = 0;
  logic [16:0] o;
  logic [15:0] op_cnt, err_cnt;

  logic        s_valid = 0, s_ready = 1, s_clr = 0;
  logic        s_in_ready, s_out_valid;
  logic [15:0] sa = 16'h1000, sb = 16'h0080;
  logic [16:0] s_o;
  logic [2:0]  s_op, s_err;

  sub16u_apx_pipe #(.W(16), .K(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .O(o),
    .op_cnt(op_cnt), .err_cnt(err_cnt), .cnt_clr(cnt_clr));

  // Narrow-counter instance so saturation is reached in a few cycles.
  sub16u_apx_pipe #(.W(16), .K(8), .CW(3)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready), .A(sa), .B(sb),
    .out_valid(s_out_valid), .out_ready(s_ready), .O(s_o),
    .op_cnt(s_op), .err_cnt(s_err), .cnt_clr(s_clr));

  always #5 clk = ~clk;

  int          pass_cnt = 0, chk_cnt = 0;
  logic [16:0] exp_q[$];
  logic        err_q[$];
  logic        chk_en = 0;
  logic [15:0] op_m = 0, err_m = 0;
  logic        mon_er;

  logic [15:0] va[9], vb[9];
  logic [16:0] vo[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [16:0] eo);
    logic [16:0] ex;
    ex = {1'b0, x} - {1'b0, y};
    exp_q.push_back(eo);
    err_q.push_back(eo != ex);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [16:0] eo);
    int n;
    n = 0;
    in_valid = 1; a = x; b = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      step();
      n++;
      if (n > 50) begin
        chk_cnt++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
    push(x, y, eo);
    step();
    in_valid = 0;
  endtask

  // Monitor: counter model plus scoreboard pop on output transfer.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("op_cnt_track", op_cnt, op_m);
      check("err_cnt_track", err_cnt, err_m);
      mon_er = 0;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_out actual=%0h required=none", o);
        end else begin
          mon_er = err_q.pop_front();
          check("O", o, exp_q.pop_front());
        end
      end
      if (rst || cnt_clr) begin
        op_m = 0; err_m = 0;
      end else if (out_valid && out_ready) begin
        if (op_m != 16'hFFFF) op_m++;
        if (mon_er && err_m != 16'hFFFF) err_m++;
      end
    end
  end

  initial begin
    va[0]=16'h1234; vb[0]=16'h0100; vo[0]=17'h01134;
    va[1]=16'h1000; vb[1]=16'h0080; vo[1]=17'h00F00;
    va[2]=16'h0000; vb[2]=16'h0100; vo[2]=17'h1FF00;
    va[3]=16'hFFFF; vb[3]=16'hFFFF; vo[3]=17'h000FF;
    va[4]=16'h0080; vb[4]=16'h0000; vo[4]=17'h00080;
    va[5]=16'h0000; vb[5]=16'h0001; vo[5]=17'h00000;
    va[6]=16'h0F00; vb[6]=16'h0180; vo[6]=17'h00D00;
    va[7]=16'h1000; vb[7]=16'h0100; vo[7]=17'h00F00;
    va[8]=16'h00FF; vb[8]=16'h0100; vo[8]=17'h1FFFF;

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_O", o, 0);
    check("rst_op_cnt", op_cnt, 0);
    step(); rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // Latency and first result
    out_ready = 1;
    send(va[0], vb[0], vo[0]);
    @(negedge clk); check("lat_c1_valid", out_valid, 0);
    step();
    @(negedge clk); check("lat_c2_valid", out_valid, 1);
    step(); step();
    @(negedge clk);
    check("first_op_cnt", op_cnt, 1);
    check("first_err_cnt", err_cnt, 0);
    step();

    // Back-to-back directed vectors
    for (int i = 1; i < 9; i++) send(va[i], vb[i], vo[i]);
    repeat (4) step();
    @(negedge clk);
    check("burst_op_cnt", op_cnt, 9);
    check("burst_err_cnt", err_cnt, 4);
    step();

    // Backpressure: two accepted, third stalls, output holds the first
    out_ready = 0;
    send(va[0], vb[0], vo[0]);
    send(va[1], vb[1], vo[1]);
    in_valid = 1; a = va[2]; b = vb[2];
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_O_hold1", o, vo[0]);
    step();
    @(negedge clk);
    check("stall_O_hold2", o, vo[0]);
    step();
    out_ready = 1;
    push(va[2], vb[2], vo[2]);
    @(negedge clk);
    check("drain_v1", out_valid, 1);
    check("drain_in_ready", in_ready, 1);
    step(); in_valid = 0;
    @(negedge clk); check("drain_v2", out_valid, 1);
    step();
    @(negedge clk); check("drain_v3", out_valid, 1);
    step(); step();

    // Reset with two results in flight
    out_ready = 0;
    send(va[3], vb[3], vo[3]);
    send(va[4], vb[4], vo[4]);
    rst = 1;
    exp_q.delete(); err_q.delete();
    @(negedge clk); check("midrst_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_op_cnt", op_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    step(); rst = 0; out_ready = 1;
    repeat (4) step();
    @(negedge clk); check("midrst_no_stale", out_valid, 0);
    step();

    // cnt_clr on the same cycle as a delivery
    send(va[1], vb[1], vo[1]);
    repeat (3) step();
    out_ready = 0;
    send(va[1], vb[1], vo[1]);
    step();
    out_ready = 1; cnt_clr = 1;
    step(); cnt_clr = 0;
    @(negedge clk);
    check("clr_op_cnt", op_cnt, 0);
    check("clr_err_cnt", err_cnt, 0);
    step();

    // Saturation on the narrow-counter instance
    s_valid = 1;
    repeat (12) step();
    @(negedge clk);
    check("sat_op_cnt", s_op, 7);
    check("sat_err_cnt", s_err, 7);
    step(); s_clr = 1;
    step(); s_clr = 0; s_valid = 0;
    @(negedge clk);
    check("sat_clr_op", s_op, 0);
    check("sat_clr_err", s_err, 0);

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
